// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter command front end.
package counter_ctrl_pkg;

  // Default width of the counter load data path.
  localparam int unsigned CNT_W_DEFAULT = 4;

  // Counter reset value; set_value resets to this so both agree after reset.
  localparam logic [3:0] RESET_COUNT = 4'b0101;

  // Debounce FSM states.
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } deb_state_e;

endpackage

// File: rtl/button_debounce.sv
// Synchronises one raw button, debounces it and emits a one-cycle pulse on
// each debounced rising edge (press). Releases produce no pulse.
module button_debounce
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_rise
);

  localparam int unsigned DCW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DCW-1:0] CNT_LAST = DCW'(DEBOUNCE_CYCLES - 1);

  logic           r_sync1;
  logic           r_sync2;
  deb_state_e     r_state;
  logic [DCW-1:0] r_cnt;
  logic           r_rise;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce FSM: a new level must hold through a full check window before it
  // is accepted; any mismatch inside the window falls back to the old level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      case (r_state)
        STABLE_LO: begin
          if (r_sync2) begin
            r_state <= CHECK_HI;
            r_cnt   <= '0;
          end
        end
        CHECK_HI: begin
          if (!r_sync2) begin
            r_state <= STABLE_LO;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= STABLE_HI;
            // The press pulse is registered here so it leaves with the level flip.
            r_rise  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STABLE_HI: begin
          if (!r_sync2) begin
            r_state <= CHECK_LO;
            r_cnt   <= '0;
          end
        end
        CHECK_LO: begin
          if (r_sync2) begin
            r_state <= STABLE_HI;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= STABLE_LO;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= STABLE_LO;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/counter_cmd_ctrl.sv
// Command front end for the 4-bit up/down counter. Turns debounced button
// presses and an optional prescaler into single-cycle enable/set pulses, and
// keeps the direction level and the load data.
module counter_cmd_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned PRESCALE        = 1000,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_step,
  input  logic             btn_dir,
  input  logic             btn_load,
  input  logic             auto_mode,
  input  logic [CNT_W-1:0] load_value,
  output logic             enable,
  output logic             set,
  output logic [CNT_W-1:0] set_value,
  output logic             up_down
);

  localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic             r_auto_s1;
  logic             r_auto_s2;
  logic [CNT_W-1:0] r_load_s1;
  logic [CNT_W-1:0] r_load_s2;
  logic [PW-1:0]    r_presc;
  logic             r_enable;
  logic             r_set;
  logic [CNT_W-1:0] r_set_value;
  logic             r_up_down;

  logic w_step_rise;
  logic w_dir_rise;
  logic w_load_rise;
  logic w_tick;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_step (
    .clk   (clk),
    .reset (reset),
    .i_btn (btn_step),
    .o_rise(w_step_rise)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_dir (
    .clk   (clk),
    .reset (reset),
    .i_btn (btn_dir),
    .o_rise(w_dir_rise)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_load (
    .clk   (clk),
    .reset (reset),
    .i_btn (btn_load),
    .o_rise(w_load_rise)
  );

  // Two-flop synchronisers for the slide switches; these are levels, not debounced.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_auto_s1 <= 1'b0;
      r_auto_s2 <= 1'b0;
      r_load_s1 <= '0;
      r_load_s2 <= '0;
    end else begin
      r_auto_s1 <= auto_mode;
      r_auto_s2 <= r_auto_s1;
      r_load_s1 <= load_value;
      r_load_s2 <= r_load_s1;
    end
  end

  // Prescaler runs only in auto mode and is parked at zero otherwise, so the
  // first tick always lands a full period after auto mode is seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else if (!r_auto_s2) begin
      r_presc <= '0;
    end else if (r_presc == PRESC_LAST) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign w_tick = r_auto_s2 && (r_presc == PRESC_LAST);

  // Output registers: load beats count (the dropped count is not replayed),
  // step presses are ignored in auto mode, direction toggles per dir press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enable    <= 1'b0;
      r_set       <= 1'b0;
      r_set_value <= CNT_W'(RESET_COUNT);
      r_up_down   <= 1'b1;
    end else begin
      r_set    <= w_load_rise;
      r_enable <= !w_load_rise && (r_auto_s2 ? w_tick : w_step_rise);
      if (w_load_rise) begin
        r_set_value <= r_load_s2;
      end
      if (w_dir_rise) begin
        r_up_down <= ~r_up_down;
      end
    end
  end

  assign enable    = r_enable;
  assign set       = r_set;
  assign set_value = r_set_value;
  assign up_down   = r_up_down;

endmodule

// File: doc/counter_cmd_ctrl.md
Name: counter_cmd_ctrl

Overview:
Front-end command stage that drives the 4-bit up/down counter's control inputs: enable, set, set_value and up_down.
- Takes raw, bouncy board inputs (push-buttons, slide switches) and synchronises and debounces them.
- Converts each press into a single-cycle command pulse.
- Optionally generates periodic auto-count ticks from a prescaler.
- Sits directly upstream of the counter; its outputs connect port-for-port to the counter's inputs.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synced cycles required before a debounced level changes (min 2)
PRESCALE, 1000, clk cycles per auto-count tick (min 2)
CNT_W, 4, width of load_value/set_value

Ports:
clk  input  1  system clock
reset  input  1  reset, asynchronous, active-high
btn_step  input  1  raw step button, async, bouncy
btn_dir  input  1  raw direction-toggle button, async, bouncy
btn_load  input  1  raw load button, async, bouncy
auto_mode  input  1  raw slide switch; 1 = prescaler-driven counting
load_value  input  CNT_W  raw switch bank, value to load
enable  output  1  one-cycle count pulse to counter
set  output  1  one-cycle load pulse to counter
set_value  output  CNT_W  load data; valid when set=1, held otherwise
up_down  output  1  direction level; 1 = up, 0 = down

Behaviour:
- All outputs registered. Reset values: enable=0, set=0, set_value=4'b0101 (matches counter reset value), up_down=1, prescaler=0, all debounced levels 0, all sync flops 0.
- Synchronisers: 2-flop on every raw input, including each load_value bit and auto_mode. auto_mode and load_value are used directly after synchronisation; they are not debounced.
- Debounce FSM per button, states STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO:
  - In STABLE_x, a synced value differing from x moves to CHECK_y and clears the counter.
  - In CHECK_y, the counter increments each cycle the synced value equals y. A mismatch returns to STABLE_x.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a match, the FSM moves to STABLE_y and the debounced level flips.
- Press = debounced 0->1 transition. Release produces no command.
- Latency: a clean raw rising edge sampled at clock edge 0 yields its output effect at edge DEBOUNCE_CYCLES+3, exactly. The output effect is an enable or set pulse, or an up_down flip.
- Step press with synced auto_mode=0: enable=1 for exactly one cycle.
- Step presses are ignored while auto_mode=1.
- Auto mode:
  - While synced auto_mode=1, the prescaler counts 0..PRESCALE-1 and wraps to 0.
  - enable=1 for one cycle each time the prescaler wraps, giving one pulse per PRESCALE cycles.
  - The first pulse occurs PRESCALE cycles after auto_mode synced high.
  - The prescaler is held at 0 whenever auto_mode=0.
- Dir press: up_down toggles on the effect edge.
  - If it coincides with an enable pulse, up_down carries the new value in that same cycle.
- Load press: set=1 for one cycle. set_value is captured from synced load_value on the same edge and held afterwards.
- Priority: set and enable are never both 1.
  - On coincidence, set wins and the enable pulse is dropped, not deferred.
  - In auto mode the prescaler keeps running, so the next tick is unaffected.
- Simultaneous presses of different buttons are each honoured per the rules above. No queuing: at most one pulse per press.
- Reset mid-debounce: all progress is discarded. A button held through reset release is seen as a fresh press after DEBOUNCE_CYCLES+3 edges.
- Bounce shorter than DEBOUNCE_CYCLES cycles produces no command.

Decomposition:
- Package counter_ctrl_pkg:
  - CNT_W default
  - RESET_COUNT = 4'b0101 (shared with the counter)
  - debounce state enum (STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO)
- Sub-module button_debounce: 2-flop sync, debounce FSM and counter, rise-pulse output.
  - Parameter DEBOUNCE_CYCLES.
  - Instantiated 3x (step, dir, load).
- The top level holds the prescaler, priority logic, up_down and set_value registers.

Test Plan:
(bench parameters DEBOUNCE_CYCLES=4, PRESCALE=5)
- Reset: assert mid-run with outputs active -> immediately enable=0, set=0, set_value=0101, up_down=1.
- Clean step press, auto_mode=0 -> single enable pulse exactly 7 edges after the raw edge. Holding the button 50 cycles gives no further pulses.
- Bounce: btn_step toggles 1,0,1,0 at 1-cycle spacing, then settles low -> no enable. Pattern followed by steady high -> exactly one pulse.
- Auto mode: auto_mode=1 for 22 cycles after sync -> 4 enable pulses, 5 cycles apart. Step presses during this window produce nothing.
- Load: load_value=1010, press load -> set=1 for one cycle with set_value=1010. Change switches to 0011 afterwards -> set_value stays 1010.
- Coincidence: load and step pressed on the same raw edge -> set pulse only, no enable. Dir and step pressed together -> enable pulse with up_down=0 in the same cycle.
